pwm_duty_capture: RTL

- Receive-side counterpart of the board's PWM LED drivers: measures an incoming PWM waveform and reports period, high time and normalised duty.
- Duty is reported on the same DUTY_W-bit brightness scale the LED drivers consume.
- Used for closed-loop checking of LED brightness and for reading external PWM sources, such as fan tachometer or servo-style inputs.
- Reports 0 % / 100 % (stuck-line) conditions via a timeout.

---
 rtl/pwm_pkg.sv | 21 ++
 rtl/pwm_duty_div.sv | 70 +++++++
 rtl/pwm_duty_capture.sv | 166 ++++++++++++++++
 3 files changed

// File: rtl/pwm_pkg.sv
// Shared constants for the PWM LED drivers and the PWM capture block.
// Holds the brightness scale, the clock-derived timeout and the capture FSM encoding.
package pwm_pkg;

  localparam int PWM_DUTY_W = 9;
  localparam int PWM_CNT_W  = 24;
  localparam int FREQUENCE  = 75_000_000;
  // 1_000_000 clk cycles, about 13.3 ms at FREQUENCE
  localparam int PWM_TIMEOUT = FREQUENCE / 75;

  typedef logic [1:0] pwm_state_t;

  localparam pwm_state_t ST_IDLE = 2'd0;
  localparam pwm_state_t ST_HIGH = 2'd1;
  localparam pwm_state_t ST_LOW  = 2'd2;

  function automatic longint cnt_limit(input int w);
    return (longint'(1) << w) - longint'(1);
  endfunction

endpackage

// File: rtl/pwm_duty_div.sv
// Restoring divider producing floor(num * 2**DUTY_W / den), one quotient bit per clk.
// Requires num < den; abort drops an in-flight division without raising done.
module pwm_duty_div
  import pwm_pkg::*;
#(
  parameter int CNT_W  = PWM_CNT_W,
  parameter int DUTY_W = PWM_DUTY_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              abort,
  input  logic [CNT_W-1:0]  num,
  input  logic [CNT_W-1:0]  den,
  output logic              busy,
  output logic              done,
  output logic [DUTY_W-1:0] quot
);

  localparam int STEP_W = $clog2(DUTY_W + 1);

  // Handshake: start is only honoured while busy is low; busy is already low
  // in the done cycle, so a new start may land on the same edge that retires
  // a result. quot is stable during the done cycle and cleared on the next start.
  logic [CNT_W:0]    rem;
  logic [CNT_W:0]    den_r;
  logic [CNT_W:0]    rem_sh;
  logic              take;
  logic [STEP_W-1:0] left;
  logic              run;

  always_comb begin
    rem_sh = rem << 1;
    take   = (rem_sh >= den_r);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rem   <= '0;
      den_r <= '0;
      quot  <= '0;
      left  <= '0;
      run   <= 1'b0;
      done  <= 1'b0;
    end else begin
      done <= 1'b0;
      if (abort) begin
        run  <= 1'b0;
        left <= '0;
      end else if (start && !run) begin
        rem   <= {1'b0, num};
        den_r <= {1'b0, den};
        quot  <= '0;
        left  <= STEP_W'(DUTY_W);
        run   <= 1'b1;
      end else if (run) begin
        rem  <= take ? (rem_sh - den_r) : rem_sh;
        quot <= {quot[DUTY_W-2:0], take};
        left <= left - STEP_W'(1);
        if (left == STEP_W'(1)) begin
          run  <= 1'b0;
          done <= 1'b1;
        end
      end
    end
  end

  assign busy = run;

endmodule

// File: rtl/pwm_duty_capture.sv
// Measures an incoming PWM waveform: period, high time and duty on the LED brightness scale.
// A line with no edge for TIMEOUT clk is reported as stuck with duty 0 or full scale.
module pwm_duty_capture
  import pwm_pkg::*;
#(
  parameter int CNT_W   = PWM_CNT_W,
  parameter int DUTY_W  = PWM_DUTY_W,
  parameter int TIMEOUT = PWM_TIMEOUT
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              pwm_in,
  output logic [CNT_W-1:0]  period,
  output logic [CNT_W-1:0]  high_time,
  output logic [DUTY_W-1:0] duty,
  output logic              valid,
  output logic              stuck,
  output logic              overrun,
  output pwm_state_t        fsm_state
);

  if (longint'(TIMEOUT) >= cnt_limit(CNT_W)) begin : g_timeout_check
    $error("pwm_duty_capture: TIMEOUT must be below 2**CNT_W-1");
  end

  localparam logic [CNT_W-1:0] CNT_MAX   = '1;
  localparam logic [CNT_W-1:0] IDLE_FIRE = CNT_W'(TIMEOUT - 1);

  logic              s1;
  logic              pwm_s;
  logic              pwm_d;
  logic              rise;
  logic              fall;
  logic              any_edge;
  logic [CNT_W-1:0]  cnt;
  logic [CNT_W-1:0]  idle_cnt;
  logic [CNT_W-1:0]  h_lat;
  logic [CNT_W-1:0]  m_per;
  logic [CNT_W-1:0]  m_high;
  pwm_state_t        state;
  logic              stuck_evt;
  logic              issue;
  logic              accept;
  logic              div_busy;
  logic              div_done;
  logic [DUTY_W-1:0] div_quot;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1    <= 1'b0;
      pwm_s <= 1'b0;
      pwm_d <= 1'b0;
    end else begin
      s1    <= pwm_in;
      pwm_s <= s1;
      pwm_d <= pwm_s;
    end
  end

  // The stuck event fires on the edge that would take the idle count to TIMEOUT,
  // so a coincident edge always wins and the event cannot repeat until an edge.
  always_comb begin
    rise      = pwm_s & ~pwm_d;
    fall      = ~pwm_s & pwm_d;
    any_edge  = rise | fall;
    stuck_evt = !any_edge && (idle_cnt == IDLE_FIRE);
    issue     = (state == ST_LOW) && rise && !stuck_evt;
    accept    = issue && !div_busy;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt      <= '0;
      idle_cnt <= '0;
    end else begin
      if (rise) begin
        cnt <= CNT_W'(1);
      end else if (cnt != CNT_MAX) begin
        cnt <= cnt + CNT_W'(1);
      end
      if (any_edge) begin
        idle_cnt <= '0;
      end else if (idle_cnt != CNT_MAX) begin
        idle_cnt <= idle_cnt + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= ST_IDLE;
      h_lat <= '0;
    end else if (stuck_evt) begin
      state <= ST_IDLE;
    end else begin
      case (state)
        ST_IDLE: if (rise) state <= ST_HIGH;
        ST_HIGH: begin
          if (fall) begin
            h_lat <= cnt;
            state <= ST_LOW;
          end
        end
        ST_LOW:  if (rise) state <= ST_HIGH;
        default: state <= ST_IDLE;
      endcase
    end
  end

  // Accepted measurements are held here so that a dropped issue never
  // disturbs the values reported with the division in flight.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      m_per  <= '0;
      m_high <= '0;
    end else if (accept) begin
      m_per  <= cnt;
      m_high <= h_lat;
    end
  end

  pwm_duty_div #(
    .CNT_W  (CNT_W),
    .DUTY_W (DUTY_W)
  ) u_div (
    .clk   (clk),
    .rst   (rst),
    .start (accept),
    .abort (stuck_evt),
    .num   (h_lat),
    .den   (cnt),
    .busy  (div_busy),
    .done  (div_done),
    .quot  (div_quot)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      period    <= '0;
      high_time <= '0;
      duty      <= '0;
      valid     <= 1'b0;
      stuck     <= 1'b0;
      overrun   <= 1'b0;
    end else begin
      valid   <= 1'b0;
      overrun <= issue && !accept;
      if (stuck_evt) begin
        period    <= '0;
        high_time <= '0;
        duty      <= pwm_s ? '1 : '0;
        stuck     <= 1'b1;
        valid     <= 1'b1;
      end else if (div_done) begin
        period    <= m_per;
        high_time <= m_high;
        duty      <= div_quot;
        stuck     <= 1'b0;
        valid     <= 1'b1;
      end
    end
  end

  assign fsm_state = state;

endmodule
